// File: rtl/commit_pkg.sv
// Shared types and constants for the commit checker: record layout, flag
// positions, error cause codes and the checker state encoding.
package commit_pkg;

   localparam int FLAG_REGWRITE = 0;
   localparam int FLAG_MEMREAD  = 1;
   localparam int FLAG_MEMWRITE = 2;
   localparam int FLAG_HALT     = 3;

   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_PC       = 3'd1;
   localparam logic [2:0] ERR_FLAGS    = 3'd2;
   localparam logic [2:0] ERR_REG      = 3'd3;
   localparam logic [2:0] ERR_RVAL     = 3'd4;
   localparam logic [2:0] ERR_ADDR     = 3'd5;
   localparam logic [2:0] ERR_MDATA    = 3'd6;
   localparam logic [2:0] ERR_OVERFLOW = 3'd7;

   typedef struct packed {
      logic [15:0] pc;
      logic [3:0]  flags;   // {halt, memwrite, memread, regwrite}
      logic [2:0]  wreg;
      logic [15:0] wdata;
      logic [15:0] addr;
      logic [15:0] mdata;
   } commit_rec_t;

   typedef enum logic {
      S_RUN  = 1'b0,
      S_DONE = 1'b1
   } chk_state_e;

   // Lowest failing cause wins; fields the golden flags mark as unused are ignored.
   function automatic logic [2:0] first_err(input commit_rec_t act, input commit_rec_t golden);
      logic [2:0] code;
      code = ERR_NONE;
      if (act.pc != golden.pc)
         code = ERR_PC;
      else if (act.flags != golden.flags)
         code = ERR_FLAGS;
      else if (golden.flags[FLAG_REGWRITE] && (act.wreg != golden.wreg))
         code = ERR_REG;
      else if (golden.flags[FLAG_REGWRITE] && (act.wdata != golden.wdata))
         code = ERR_RVAL;
      else if ((golden.flags[FLAG_MEMREAD] || golden.flags[FLAG_MEMWRITE]) &&
               (act.addr != golden.addr))
         code = ERR_ADDR;
      else if (golden.flags[FLAG_MEMWRITE] && (act.mdata != golden.mdata))
         code = ERR_MDATA;
      return code;
   endfunction

endpackage

// File: rtl/commit_checker_if.sv
// Retire-event tap from the core plus the golden-record valid/ready stream.
interface commit_checker_if;
   logic        commit_valid;
   logic [15:0] commit_pc;
   logic        commit_regwrite;
   logic [2:0]  commit_wreg;
   logic [15:0] commit_wdata;
   logic        commit_memread;
   logic        commit_memwrite;
   logic [15:0] commit_addr;
   logic [15:0] commit_mdata;
   logic        commit_halt;

   logic        exp_valid;
   logic        exp_ready;
   logic [3:0]  exp_flags;
   logic [15:0] exp_pc;
   logic [15:0] exp_rval;
   logic [15:0] exp_addr;
   logic [15:0] exp_mval;
   logic [2:0]  exp_reg;

   modport master (
      output commit_valid, commit_pc, commit_regwrite, commit_wreg, commit_wdata,
             commit_memread, commit_memwrite, commit_addr, commit_mdata, commit_halt,
             exp_valid, exp_flags, exp_pc, exp_rval, exp_addr, exp_mval, exp_reg,
      input  exp_ready
   );

   modport slave (
      input  commit_valid, commit_pc, commit_regwrite, commit_wreg, commit_wdata,
             commit_memread, commit_memwrite, commit_addr, commit_mdata, commit_halt,
             exp_valid, exp_flags, exp_pc, exp_rval, exp_addr, exp_mval, exp_reg,
      output exp_ready
   );
endinterface

// File: rtl/commit_fifo.sv
// Synchronous FIFO of retire records. Pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate count.
module commit_fifo
   import commit_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push_i,
   input  logic        pop_i,
   input  commit_rec_t din_i,
   output logic        full_o,
   output logic        empty_o,
   output commit_rec_t head_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   commit_rec_t mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        wr_en;
   logic        rd_en;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   // A push into a full FIFO is only accepted when the head leaves the same cycle.
   assign wr_en = push_i && (!full_o || pop_i);
   assign rd_en = pop_i && !empty_o;

   // Pointer advance.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   // Pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage; contents are meaningless until written, so no reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/commit_checker.sv
// Commit monitor: buffers retire events, compares each against the golden
// stream and latches the first error or the pass verdict at HALT.
//
//   state  | meaning
//   S_RUN  | buffering retires and comparing against golden records
//   S_DONE | verdict latched; no pops, pushes or new errors until reset
module commit_checker
   import commit_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   commit_checker_if.slave  bus,
   output logic [31:0]      inst_count,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic [31:0]      err_inum,
   output logic [2:0]       err_field
);

   chk_state_e  state_q, state_d;
   commit_rec_t push_rec;
   commit_rec_t exp_rec;
   commit_rec_t head_rec;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_push;
   logic        push_req;
   logic        cmp_en;
   logic        overflow;
   logic        halt_ok;
   logic [2:0]  cmp_code;

   logic [31:0] inst_count_q;
   logic        pass_q;
   logic        fail_q;
   logic [31:0] err_inum_q;
   logic [2:0]  err_field_q;

   assign push_rec = '{pc:    bus.commit_pc,
                       flags: {bus.commit_halt, bus.commit_memwrite,
                               bus.commit_memread, bus.commit_regwrite},
                       wreg:  bus.commit_wreg,
                       wdata: bus.commit_wdata,
                       addr:  bus.commit_addr,
                       mdata: bus.commit_mdata};

   assign exp_rec  = '{pc:    bus.exp_pc,
                       flags: bus.exp_flags,
                       wreg:  bus.exp_reg,
                       wdata: bus.exp_rval,
                       addr:  bus.exp_addr,
                       mdata: bus.exp_mval};

   commit_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .pop_i   (cmp_en),
      .din_i   (push_rec),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (head_rec)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_RUN;
      else        state_q <= state_d;
   end

   // Next state: any verdict (error, overflow, matched halt) is final.
   always_comb begin
      state_d = state_q;
      if ((state_q == S_RUN) && ((cmp_code != ERR_NONE) || overflow || halt_ok))
         state_d = S_DONE;
   end

   // Per-cycle controls; the core cannot stall, so an overflow drops the event.
   always_comb begin
      cmp_en    = 1'b0;
      push_req  = 1'b0;
      overflow  = 1'b0;
      fifo_push = 1'b0;
      cmp_code  = ERR_NONE;
      halt_ok   = 1'b0;
      if (state_q == S_RUN) begin
         cmp_en    = !fifo_empty && bus.exp_valid;
         push_req  = bus.commit_valid;
         overflow  = push_req && fifo_full && !cmp_en;
         fifo_push = push_req && !overflow;
         if (cmp_en) begin
            cmp_code = first_err(head_rec, exp_rec);
            halt_ok  = (cmp_code == ERR_NONE) && exp_rec.flags[FLAG_HALT];
         end
      end
   end

   assign bus.exp_ready = cmp_en;

   // Status: record counter and first-error / verdict latches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_count_q <= '0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
         err_inum_q   <= '0;
         err_field_q  <= ERR_NONE;
      end else begin
         if (cmp_en) inst_count_q <= inst_count_q + 32'd1;
         if (cmp_code != ERR_NONE) begin
            fail_q      <= 1'b1;
            err_inum_q  <= inst_count_q;
            err_field_q <= cmp_code;
         end else if (overflow) begin
            fail_q      <= 1'b1;
            err_inum_q  <= inst_count_q;
            err_field_q <= ERR_OVERFLOW;
         end else if (halt_ok) begin
            pass_q <= 1'b1;
         end
      end
   end

   assign inst_count = inst_count_q;
   assign done       = (state_q == S_DONE);
   assign pass       = pass_q;
   assign fail       = fail_q;
   assign err_inum   = err_inum_q;
   assign err_field  = err_field_q;

endmodule
